// File: rtl/mult_pkg.sv
// Shared definitions for the HI/LO multiply unit: operand width default,
// op-code and FSM state encodings, and small op-decode helpers.
package mult_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_MTHI  = 3'd2,
        OP_MTLO  = 3'd3,
        OP_MADD  = 3'd4,
        OP_MADDU = 3'd5,
        OP_MSUB  = 3'd6,
        OP_MSUBU = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_ACC  = 2'd2
    } state_e;

    // Ops whose product is taken as two's complement
    function automatic logic op_signed(op_e op);
        return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

    // Plain multiply that overwrites {hi,lo}
    function automatic logic op_is_mul(op_e op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    // Multiply-accumulate family
    function automatic logic op_is_acc(op_e op);
        return (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

    // Accumulate ops that subtract the product
    function automatic logic op_is_sub(op_e op);
        return (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

endpackage

// File: rtl/mult_hilo_unit_if.sv
// Request channel from the EX stage into the HI/LO unit.
// master = EX stage (issues ops, flush), slave = mult_hilo_unit.
interface mult_hilo_unit_if
    import mult_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) ();
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_op;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic            flush;

    modport master (output req_valid, req_op, req_a, req_b, flush, input req_ready);
    modport slave  (input req_valid, req_op, req_a, req_b, flush, output req_ready);
endinterface

// File: rtl/hilo_acc.sv
// 2*XLEN accumulator adder/subtractor for MADD/MSUB-family ops.
// Only exists when MULT_HILO_ACC_EN is defined.
`ifdef MULT_HILO_ACC_EN
module hilo_acc
    import mult_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [2*XLEN-1:0] prod_i,
    input  logic              sub_i,
    output logic [2*XLEN-1:0] sum_o
);
    // Wrap-around add or subtract; no overflow detection
    always_comb begin
        sum_o = sub_i ? (acc_i - prod_i) : (acc_i + prod_i);
    end
endmodule
`endif

// File: rtl/mult_hilo_unit.sv
// HI/LO register unit driving an external one-register-stage multiplier.
// MULT/MULTU take IDLE->MUL->IDLE; MTHI/MTLO write at the accept edge.
// Optional feature macro MULT_HILO_ACC_EN adds MADD/MADDU/MSUB/MSUBU via an
// ACC state and a product register; without it those ops are accepted as no-ops.
module mult_hilo_unit
    import mult_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    mult_hilo_unit_if.slave   req,
    output logic [XLEN-1:0]   mul_op1,
    output logic [XLEN-1:0]   mul_op2,
    output logic              mul_sign,
    input  logic [2*XLEN-1:0] mul_out,
    output logic [XLEN-1:0]   hi,
    output logic [XLEN-1:0]   lo,
    output logic              busy
);

    state_e            state_q, state_d;
    logic [2*XLEN-1:0] hilo_q, hilo_d;
    op_e               op;
    logic              accept;

    assign op     = op_e'(req.req_op);
    // Flush wins over a simultaneous request
    assign accept = req.req_valid & req.req_ready & ~req.flush;

`ifdef MULT_HILO_ACC_EN
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic              acc_q, acc_d;
    logic              sub_q, sub_d;
    logic [2*XLEN-1:0] acc_res;

    hilo_acc #(.XLEN(XLEN)) u_acc (
        .acc_i  (hilo_q),
        .prod_i (prod_q),
        .sub_i  (sub_q),
        .sum_o  (acc_res)
    );
`endif

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state: flush in any busy state abandons the op
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && op_is_mul(op)) state_d = ST_MUL;
`ifdef MULT_HILO_ACC_EN
                else if (accept && op_is_acc(op)) state_d = ST_MUL;
`endif
            end
            ST_MUL: begin
`ifdef MULT_HILO_ACC_EN
                if (req.flush) state_d = ST_IDLE;
                else           state_d = acc_q ? ST_ACC : ST_IDLE;
`else
                state_d = ST_IDLE;
`endif
            end
`ifdef MULT_HILO_ACC_EN
            ST_ACC:  state_d = ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: handshake/status from state, multiplier operands straight from the request
    always_comb begin
        req.req_ready = (state_q == ST_IDLE);
        busy          = (state_q != ST_IDLE);
        mul_op1       = req.req_a;
        mul_op2       = req.req_b;
        mul_sign      = op_signed(op);
    end

    // HI/LO (and accumulate context) next-state
    always_comb begin
        hilo_d = hilo_q;
`ifdef MULT_HILO_ACC_EN
        prod_d = prod_q;
        acc_d  = acc_q;
        sub_d  = sub_q;
        if (accept) begin
            acc_d = op_is_acc(op);
            sub_d = op_is_sub(op);
        end
        if (state_q == ST_MUL) prod_d = mul_out;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept && op == OP_MTHI) hilo_d[2*XLEN-1:XLEN] = req.req_a;
                if (accept && op == OP_MTLO) hilo_d[XLEN-1:0]      = req.req_a;
            end
            ST_MUL: begin
`ifdef MULT_HILO_ACC_EN
                if (!req.flush && !acc_q) hilo_d = mul_out;
`else
                if (!req.flush) hilo_d = mul_out;
`endif
            end
`ifdef MULT_HILO_ACC_EN
            ST_ACC: begin
                if (!req.flush) hilo_d = acc_res;
            end
`endif
            default: ;
        endcase
    end

    // Architectural HI/LO
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) hilo_q <= '0;
        else       hilo_q <= hilo_d;
    end

`ifdef MULT_HILO_ACC_EN
    // Product and pending-accumulate context
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prod_q <= '0;
            acc_q  <= 1'b0;
            sub_q  <= 1'b0;
        end else begin
            prod_q <= prod_d;
            acc_q  <= acc_d;
            sub_q  <= sub_d;
        end
    end
`endif

    assign hi = hilo_q[2*XLEN-1:XLEN];
    assign lo = hilo_q[XLEN-1:0];

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Scoreboard bench for mult_hilo_unit: the driver pushes the expected HI/LO
// and busy length per op; a monitor pops and compares when the op completes.
module tb_mult_hilo_unit;
    import mult_pkg::*;

`ifdef MULT_HILO_ACC_EN
    localparam int ACC_DUR = 2;
`else
    localparam int ACC_DUR = 0;
`endif

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          busy;
        string       name;
    } exp_t;

    logic        clk;
    logic        rstn;
    logic [31:0] mul_op1, mul_op2, hi, lo;
    logic        mul_sign, busy;
    logic [63:0] mul_out;

    mult_hilo_unit_if #(.XLEN(32)) bus ();

    mult_hilo_unit #(.XLEN(32)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .req      (bus),
        .mul_op1  (mul_op1),
        .mul_op2  (mul_op2),
        .mul_sign (mul_sign),
        .mul_out  (mul_out),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External one-stage multiplier
    always @(posedge clk) begin
        if (mul_sign) mul_out <= 64'(longint'($signed(mul_op1)) * longint'($signed(mul_op2)));
        else          mul_out <= {32'b0, mul_op1} * {32'b0, mul_op2};
    end

    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    logic [63:0] m_hilo = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // k: cycle (1 = presenting cycle) in which flush is raised, 0 = never
    // r: cycle in which rstn is pulsed low, 0 = never
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int k, input int r, input string name);
        int          dur;
        int          j;
        longint      sa, sbv;
        logic [63:0] sp, up, ua, ub;
        exp_t        e;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        sp  = 64'(sa * sbv);
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        up  = ua * ub;
        case (op)
            OP_MULT, OP_MULTU: dur = 1;
            OP_MTHI, OP_MTLO:  dur = 0;
            default:           dur = ACC_DUR;
        endcase
        if (k == 1) e.busy = 0;
        else if (r >= 2 && r <= dur + 1) begin
            m_hilo = '0;
            e.busy = r - 2;
        end else if (k >= 2 && k <= dur + 1) e.busy = k - 1;
        else begin
            e.busy = dur;
            case (op)
                OP_MTHI:  m_hilo[63:32] = a;
                OP_MTLO:  m_hilo[31:0]  = a;
                OP_MULT:  m_hilo = sp;
                OP_MULTU: m_hilo = up;
`ifdef MULT_HILO_ACC_EN
                OP_MADD:  m_hilo = m_hilo + sp;
                OP_MADDU: m_hilo = m_hilo + up;
                OP_MSUB:  m_hilo = m_hilo - sp;
                OP_MSUBU: m_hilo = m_hilo - up;
`endif
                default: ;
            endcase
        end
        e.hi   = m_hilo[63:32];
        e.lo   = m_hilo[31:0];
        e.name = name;
        sb.push_back(e);

        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.flush     = (k == 1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        j = 2;
        forever begin
            if (bus.req_ready) break;
            if (j > 12) begin
                checks++;
                errors++;
                $display("FAIL %s ready_timeout actual=0 required=1", name);
                break;
            end
            bus.flush = (k == j);
            if (r == j) begin
                #1 rstn = 1'b0;
                #2 rstn = 1'b1;
            end
            @(posedge clk); #1;
            j++;
        end
        bus.flush = 1'b0;
        @(posedge clk); #1;
    endtask

    // Monitor: an op presented while ready is followed until busy drops
    exp_t me;
    int   nb;
    logic exp_sign;
    initial begin
        forever begin
            @(negedge clk);
            if (rstn && bus.req_valid && bus.req_ready) begin
                exp_sign = (bus.req_op == OP_MULT) || (bus.req_op == OP_MADD) || (bus.req_op == OP_MSUB);
                chk("mul_sign", 64'(mul_sign), 64'(exp_sign));
                chk("mul_op1", 64'(mul_op1), 64'(bus.req_a));
                chk("mul_op2", 64'(mul_op2), 64'(bus.req_b));
                nb = 0;
                forever begin
                    @(negedge clk);
                    if (!busy) break;
                    chk("ready_while_busy", 64'(bus.req_ready), 64'd0);
                    nb++;
                    if (nb > 10) begin
                        checks++;
                        errors++;
                        $display("FAIL busy_timeout actual=%0d required<=2", nb);
                        break;
                    end
                end
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow actual=empty required=item");
                end else begin
                    me = sb.pop_front();
                    chk({me.name, "_hi"}, 64'(hi), 64'(me.hi));
                    chk({me.name, "_lo"}, 64'(lo), 64'(me.lo));
                    chk({me.name, "_busy"}, 64'(nb), 64'(me.busy));
                    chk({me.name, "_ready"}, 64'(bus.req_ready), 64'd1);
                end
            end
        end
    end

    logic [31:0] ra, rb;
    logic [2:0]  rop;
    int          rk;

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rstn          = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = 3'd0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.flush     = 1'b0;
        #12;
        chk("rst_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;

        do_op(OP_MTLO, 32'd5, 32'd0, 0, 0, "mtlo5");
        do_op(OP_MULT, 32'd3, 32'd4, 2, 0, "mult_flush_mul");
        do_op(OP_MTHI, 32'd7, 32'd0, 1, 0, "mthi_flush_accept");
        do_op(OP_MADD, 32'd3, 32'd4, 0, 0, "madd3x4");
        do_op(OP_MTHI, 32'd0, 32'd0, 0, 0, "mthi0");
        do_op(OP_MTLO, 32'd0, 32'd0, 0, 0, "mtlo0");
        do_op(OP_MSUBU, 32'd1, 32'd1, 0, 0, "msubu1x1");
        do_op(OP_MULT, 32'hFFFF_FFFF, 32'd2, 0, 0, "mult_m1x2");
        do_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 0, 0, "multu_ffx2");
        do_op(OP_MADD, 32'd2, 32'd3, 3, 0, "madd_flush_acc");
        do_op(OP_MTHI, 32'd9, 32'd0, 0, 0, "mthi9");
        do_op(OP_MULT, 32'd7, 32'd7, 0, 2, "mult_reset_mul");
        do_op(OP_MTLO, 32'd3, 32'd0, 0, 0, "mtlo_after_reset");

        for (int i = 0; i < 60; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = pick();
            rb  = pick();
            rk  = $urandom_range(0, 9);
            rk  = (rk < 7) ? 0 : rk - 6;
            do_op(rop, ra, rb, rk, 0, "rand");
        end

        repeat (3) @(posedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
